// File: rtl/lock_pkg.sv
// Shared definitions for the lock requester: FSM state set, system constants
// and a width helper for the shared wait/gap timer.
package lock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_OWN  = 2'd2,
        ST_GAP  = 2'd3
    } lock_state_e;

    localparam int NUM_CLIENTS = 4;
    localparam int DEF_LEN_W   = 8;
    localparam int DEF_TIMEOUT = 16;
    localparam int DEF_GAP     = 2;

    // Bits needed to hold load values up to max(timeout, gap) - 1.
    function automatic int timer_width(input int timeout, input int gap);
        int m;
        m = (timeout > gap) ? timeout : gap;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/lock_requester_if.sv
// Job, arbiter and beat signals of one lock requester, grouped for the
// requester (slave) and for whoever drives it (master).
interface lock_requester_if #(
    parameter int LEN_W = 8
);
    logic             job_valid;
    logic             job_ready;
    logic [LEN_W-1:0] job_len;
    logic             req;
    logic             grant;
    logic             beat_valid;
    logic             beat_last;
    logic [LEN_W-1:0] beat_cnt;
    logic             busy;
    logic             done;
    logic             timeout_err;

    modport slave (
        input  job_valid, job_len, grant,
        output job_ready, req, beat_valid, beat_last, beat_cnt, busy, done, timeout_err
    );

    modport master (
        output job_valid, job_len, grant,
        input  job_ready, req, beat_valid, beat_last, beat_cnt, busy, done, timeout_err
    );
endinterface

// File: rtl/lock_wait_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
// Shared between the request timeout and the post-release idle gap.
module lock_wait_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_expired
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/lock_requester.sv
// Client-side agent of the fixed-priority lock arbiter: requests the lock,
// streams a job's beats while granted, then releases and idles for a gap.
module lock_requester
    import lock_pkg::*;
#(
    parameter int LEN_W   = DEF_LEN_W,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int GAP     = DEF_GAP
) (
    input  logic               clk,
    input  logic               rst_n,
    lock_requester_if.slave    bus
);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_REQ  = ST_REQ;
    localparam logic [1:0] S_OWN  = ST_OWN;
    localparam logic [1:0] S_GAP  = ST_GAP;

    localparam int               CNT_W    = timer_width(TIMEOUT, GAP);
    localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP - 1);

    logic [1:0]       r_state;
    logic             r_req;
    logic             r_done;
    logic             r_timeout_err;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_beat_cnt;

    logic             w_accept;
    logic             w_len_zero;
    logic             w_beat;
    logic             w_last_beat;
    logic             w_expired;
    logic             w_timer_load;
    logic [CNT_W-1:0] w_timer_val;
    logic             w_timer_dec;

    assign w_accept    = (r_state == S_IDLE) && bus.job_valid;
    assign w_len_zero  = (bus.job_len == '0);
    assign w_beat      = (r_state == S_OWN) && bus.grant;
    assign w_last_beat = (r_beat_cnt == (r_len - LEN_W'(1)));

    // The timer counts remaining wait cycles in REQ and remaining idle cycles in GAP.
    always_comb begin
        w_timer_load = 1'b0;
        w_timer_val  = GAP_LOAD;
        w_timer_dec  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.job_valid) begin
                    w_timer_load = 1'b1;
                    w_timer_val  = w_len_zero ? GAP_LOAD : TO_LOAD;
                end
            end
            S_REQ: begin
                if (!bus.grant) begin
                    if (w_expired) begin
                        w_timer_load = 1'b1;
                    end else begin
                        w_timer_dec = 1'b1;
                    end
                end
            end
            S_OWN: begin
                if (w_beat && w_last_beat) begin
                    w_timer_load = 1'b1;
                end
            end
            S_GAP: begin
                w_timer_dec = 1'b1;
            end
            default: begin
                w_timer_load = 1'b0;
            end
        endcase
    end

    lock_wait_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_timer_load),
        .i_load_val (w_timer_val),
        .i_dec      (w_timer_dec),
        .o_expired  (w_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_req         <= 1'b0;
            r_done        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_beat_cnt    <= '0;
        end else begin
            r_done        <= 1'b0;
            r_timeout_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.job_valid) begin
                        if (w_len_zero) begin
                            r_state <= S_GAP;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_REQ;
                            r_req   <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    // A grant in the final wait cycle wins over the timeout.
                    if (bus.grant) begin
                        r_state <= S_OWN;
                    end else if (w_expired) begin
                        r_state       <= S_GAP;
                        r_req         <= 1'b0;
                        r_timeout_err <= 1'b1;
                    end
                end
                S_OWN: begin
                    if (w_beat) begin
                        if (w_last_beat) begin
                            r_state    <= S_GAP;
                            r_req      <= 1'b0;
                            r_done     <= 1'b1;
                            r_beat_cnt <= '0;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + LEN_W'(1);
                        end
                    end
                end
                S_GAP: begin
                    if (w_expired) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_len <= bus.job_len;
        end
    end

    assign bus.job_ready   = (r_state == S_IDLE);
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.req         = r_req;
    assign bus.done        = r_done;
    assign bus.timeout_err = r_timeout_err;
    assign bus.beat_valid  = w_beat;
    assign bus.beat_last   = w_beat && w_last_beat;
    assign bus.beat_cnt    = r_beat_cnt;

endmodule

// File: tb/tb_lock_requester.sv
// Bench for lock_requester: directed vector table, multi-cycle corner
// sequences and random traffic against a job-level reference model.
module tb_lock_requester;

    localparam int LEN_W   = 8;
    localparam int TIMEOUT = 16;
    localparam int GAP     = 2;

    logic clk;
    logic rst_n;

    lock_requester_if #(.LEN_W(LEN_W)) bus ();

    lock_requester #(
        .LEN_W   (LEN_W),
        .TIMEOUT (TIMEOUT),
        .GAP     (GAP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: job progress tracked as counts, not as FSM states.
    bit m_req_pending;
    bit m_owning;
    bit m_done;
    bit m_to;
    int m_len;
    int m_sent;
    int m_waited;
    int m_gap_left;

    logic             cur_r;
    logic             cur_jv;
    logic [LEN_W-1:0] cur_len;
    logic             cur_g;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    function automatic bit m_idle();
        return !m_req_pending && !m_owning && (m_gap_left == 0);
    endfunction

    task automatic model_reset();
        m_req_pending = 0; m_owning = 0; m_done = 0; m_to = 0;
        m_len = 0; m_sent = 0; m_waited = 0; m_gap_left = 0;
    endtask

    task automatic model_update();
        bit was_idle;
        if (!cur_r) begin
            model_reset();
            return;
        end
        was_idle = m_idle();
        m_done = 0;
        m_to   = 0;
        if (was_idle) begin
            if (cur_jv) begin
                if (cur_len == 0) begin
                    m_done     = 1;
                    m_gap_left = GAP;
                end else begin
                    m_len         = int'(cur_len);
                    m_req_pending = 1;
                    m_waited      = 0;
                end
            end
        end else if (m_req_pending) begin
            if (cur_g) begin
                m_req_pending = 0;
                m_owning      = 1;
                m_sent        = 0;
            end else if (m_waited == TIMEOUT - 1) begin
                m_req_pending = 0;
                m_to          = 1;
                m_gap_left    = GAP;
            end else begin
                m_waited++;
            end
        end else if (m_owning) begin
            if (cur_g) begin
                if (m_sent + 1 == m_len) begin
                    m_owning   = 0;
                    m_done     = 1;
                    m_gap_left = GAP;
                    m_sent     = 0;
                end else begin
                    m_sent++;
                end
            end
        end else begin
            m_gap_left--;
        end
    endtask

    task automatic set_in(input logic r, input logic jv, input logic [LEN_W-1:0] len, input logic g);
        cur_r = r; cur_jv = jv; cur_len = len; cur_g = g;
        rst_n         = r;
        bus.job_valid = jv;
        bus.job_len   = len;
        bus.grant     = g;
        #2;
    endtask

    task automatic check_model();
        bit bv;
        bv = m_owning && cur_g;
        chk("job_ready",   bus.job_ready,   m_idle());
        chk("busy",        bus.busy,        !m_idle());
        chk("req",         bus.req,         m_req_pending || m_owning);
        chk("beat_valid",  bus.beat_valid,  bv);
        chk("beat_last",   bus.beat_last,   bv && (m_sent == m_len - 1));
        chk("beat_cnt",    bus.beat_cnt,    m_sent);
        chk("done",        bus.done,        m_done);
        chk("timeout_err", bus.timeout_err, m_to);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic step(input logic r, input logic jv, input logic [LEN_W-1:0] len, input logic g);
        set_in(r, jv, len, g);
        check_model();
        tick();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, 1'b0);
    endtask

    typedef struct {
        logic             jv;
        logic [LEN_W-1:0] len;
        logic             g;
        logic             e_req;
        logic             e_bv;
        logic             e_bl;
        logic [LEN_W-1:0] e_cnt;
        logic             e_done;
        logic             e_to;
        logic             e_rdy;
        logic             e_busy;
    } vec_t;

    vec_t tbl [15];

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t got=running expected=finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int req_hi, to_cnt, bv_cnt, done_cnt, drop_left;
        bit seen;
        int gp;

        // Cycles 2..9: len=3 with grant tied high; then back-to-back zero-length jobs.
        tbl = '{
            '{1'b1, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0},
            '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1},
            '{1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1},
            '{1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1},
            '{1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd2, 1'b0, 1'b0, 1'b0, 1'b1},
            '{1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1},
            '{1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1},
            '{1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0},
            '{1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0},
            '{1'b1, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1},
            '{1'b1, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1},
            '{1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0},
            '{1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1},
            '{1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1},
            '{1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0}
        };

        model_reset();
        set_in(1'b0, 1'b0, '0, 1'b0);
        @(posedge clk); #1;
        tick();
        tick();

        for (int i = 0; i < 15; i++) begin
            set_in(1'b1, tbl[i].jv, tbl[i].len, tbl[i].g);
            check_model();
            chk($sformatf("tbl%0d_req", i),        bus.req,         tbl[i].e_req);
            chk($sformatf("tbl%0d_beat_valid", i), bus.beat_valid,  tbl[i].e_bv);
            chk($sformatf("tbl%0d_beat_last", i),  bus.beat_last,   tbl[i].e_bl);
            chk($sformatf("tbl%0d_beat_cnt", i),   bus.beat_cnt,    tbl[i].e_cnt);
            chk($sformatf("tbl%0d_done", i),       bus.done,        tbl[i].e_done);
            chk($sformatf("tbl%0d_timeout", i),    bus.timeout_err, tbl[i].e_to);
            chk($sformatf("tbl%0d_job_ready", i),  bus.job_ready,   tbl[i].e_rdy);
            chk($sformatf("tbl%0d_busy", i),       bus.busy,        tbl[i].e_busy);
            tick();
        end
        idle_cycles(2);

        // Timeout: grant never arrives.
        req_hi = 0; to_cnt = 0; bv_cnt = 0;
        step(1'b1, 1'b1, 8'd4, 1'b0);
        for (int i = 0; i < 24; i++) begin
            set_in(1'b1, 1'b0, '0, 1'b0);
            check_model();
            if (bus.req === 1'b1) req_hi++;
            if (bus.timeout_err === 1'b1) to_cnt++;
            if (bus.beat_valid === 1'b1) bv_cnt++;
            tick();
        end
        chk("timeout_req_cycles", req_hi, TIMEOUT);
        chk("timeout_pulses", to_cnt, 1);
        chk("timeout_no_beats", bv_cnt, 0);

        // Grant arriving in the last wait cycle is a grant.
        to_cnt = 0; done_cnt = 0; bv_cnt = 0;
        step(1'b1, 1'b1, 8'd2, 1'b0);
        for (int i = 0; i < TIMEOUT + 10; i++) begin
            set_in(1'b1, 1'b0, '0, (i >= TIMEOUT - 1));
            check_model();
            if (bus.timeout_err === 1'b1) to_cnt++;
            if (bus.done === 1'b1) done_cnt++;
            if (bus.beat_valid === 1'b1) bv_cnt++;
            tick();
        end
        chk("late_grant_no_timeout", to_cnt, 0);
        chk("late_grant_done", done_cnt, 1);
        chk("late_grant_beats", bv_cnt, 2);

        // Pre-emption after two beats: three cycles without grant.
        done_cnt = 0; bv_cnt = 0; drop_left = 3;
        step(1'b1, 1'b1, 8'd5, 1'b1);
        for (int i = 0; i < 16; i++) begin
            logic g;
            g = !(bv_cnt == 2 && drop_left > 0);
            set_in(1'b1, 1'b0, '0, g);
            check_model();
            if (!g) begin
                drop_left--;
                chk("preempt_cnt_hold", bus.beat_cnt, 2);
                chk("preempt_req_held", bus.req, 1);
            end
            if (bus.beat_valid === 1'b1) bv_cnt++;
            if (bus.done === 1'b1) done_cnt++;
            tick();
        end
        chk("preempt_beats", bv_cnt, 5);
        chk("preempt_done", done_cnt, 1);

        // Reset during beat 1 of a 4-beat job.
        step(1'b1, 1'b1, 8'd4, 1'b1);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            set_in(1'b1, 1'b0, '0, 1'b1);
            check_model();
            seen = (bus.beat_valid === 1'b1) && (bus.beat_cnt === 8'd0);
            tick();
        end
        chk("rst_mid_reached_own", seen, 1);
        step(1'b0, 1'b0, '0, 1'b1);
        set_in(1'b1, 1'b0, '0, 1'b1);
        check_model();
        chk("rst_mid_req", bus.req, 0);
        chk("rst_mid_ready", bus.job_ready, 1);
        chk("rst_mid_done", bus.done, 0);
        tick();
        done_cnt = 0; bv_cnt = 0;
        step(1'b1, 1'b1, 8'd1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            set_in(1'b1, 1'b0, '0, 1'b1);
            check_model();
            if (bus.beat_valid === 1'b1) bv_cnt++;
            if (bus.done === 1'b1) done_cnt++;
            tick();
        end
        chk("after_rst_beats", bv_cnt, 1);
        chk("after_rst_done", done_cnt, 1);

        // Random traffic with a grant probability that drifts per segment.
        gp = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 64 == 0) gp = $urandom_range(0, 100);
            step(($urandom_range(0, 199) != 0),
                 1'($urandom_range(0, 1)),
                 LEN_W'($urandom_range(0, 9)),
                 ($urandom_range(0, 99) < gp));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
